// File: rtl/cfi_shadow_stack_ctrl_if.sv
// Commit-port bundle feeding the CFI shadow stack: two commit slots,
// port 0 older; strobe, call/ret flags, link address and return target.
interface cfi_shadow_stack_ctrl_if #(
  parameter int XLEN = 64
);
  logic [1:0]           commit_ack_i;
  logic [1:0]           is_call_i;
  logic [1:0]           is_ret_i;
  logic [1:0][XLEN-1:0] link_addr_i;
  logic [1:0][XLEN-1:0] ret_target_i;

  modport master (
    output commit_ack_i, is_call_i, is_ret_i,
    output link_addr_i, ret_target_i
  );

  modport slave (
    input commit_ack_i, is_call_i, is_ret_i,
    input link_addr_i, ret_target_i
  );
endinterface

// File: rtl/cfi_shadow_stack_ctrl.sv
// Return-address shadow stack + violation sequencer for the commit stage.
// Ports: clk_i, rst_i (sync, active-high), cm_if (commit bus, slave),
//   arm_i/clear_i pulses; armed_o, halt_commit_o, violation_o,
//   viol_code_o (01 mismatch, 10 underflow, 11 overflow), viol_cnt_o, depth_o.
// Option: CFI_SS_OVERFLOW_TRAP_EN makes a push into a full stack a violation
//   instead of overwriting the oldest entry.
module cfi_shadow_stack_ctrl #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 64,
  parameter int CNT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  cfi_shadow_stack_ctrl_if.slave     cm_if,
  input  logic                       arm_i,
  input  logic                       clear_i,
  output logic                       armed_o,
  output logic                       halt_commit_o,
  output logic                       violation_o,
  output logic [1:0]                 viol_code_o,
  output logic [CNT_W-1:0]           viol_cnt_o,
  output logic [$clog2(DEPTH):0]     depth_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_ARMED, S_HALTED
  } state_t;

  state_t            r_state, w_state;
  logic [XLEN-1:0]   r_stack [DEPTH];
  logic [AW-1:0]     r_ptr, w_ptr;
  logic [OW-1:0]     r_occ, w_occ;
  logic              r_viol, w_viol;
  logic [1:0]        r_code, w_code;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]           w_ev;
  logic [1:0]           w_we;
  logic [1:0][AW-1:0]   w_wa;
  logic [1:0][XLEN-1:0] w_wd;
  logic [XLEN-1:0]      w_top;

  assign w_ev = cm_if.commit_ack_i
              & (cm_if.is_call_i | cm_if.is_ret_i);

  // Port 0 then port 1, each as pop-then-push; the first violation
  // stops everything after it in the same cycle.
  always_comb begin
    w_ptr  = r_ptr;
    w_occ  = r_occ;
    w_viol = 1'b0;
    w_code = 2'b00;
    w_we   = '0;
    w_wa   = '0;
    w_wd   = '0;
    w_top  = '0;
    for (int p = 0; p < 2; p++) begin
      if (r_state == S_ARMED && !w_viol && w_ev[p]) begin
        if (cm_if.is_ret_i[p]) begin
          if (w_occ == '0) begin
            w_viol = 1'b1;
            w_code = 2'b10;
          end else begin
            w_top = r_stack[w_ptr - AW'(1)];
            // port 0's push is not in the array yet
            if (p == 1 && w_we[0] && w_wa[0] == w_ptr - AW'(1))
              w_top = w_wd[0];
            w_ptr = w_ptr - AW'(1);
            w_occ = w_occ - OW'(1);
            if (w_top != cm_if.ret_target_i[p]) begin
              w_viol = 1'b1;
              w_code = 2'b01;
            end
          end
        end
        if (cm_if.is_call_i[p] && !w_viol) begin
          if (w_occ == OW'(DEPTH)) begin
`ifdef CFI_SS_OVERFLOW_TRAP_EN
            w_viol = 1'b1;
            w_code = 2'b11;
`else
            // circular overwrite of the oldest entry
            w_we[p] = 1'b1;
            w_wa[p] = w_ptr;
            w_wd[p] = cm_if.link_addr_i[p];
            w_ptr   = w_ptr + AW'(1);
`endif
          end else begin
            w_we[p] = 1'b1;
            w_wa[p] = w_ptr;
            w_wd[p] = cm_if.link_addr_i[p];
            w_ptr   = w_ptr + AW'(1);
            w_occ   = w_occ + OW'(1);
          end
        end
      end
    end

    w_state = r_state;
    unique case (r_state)
      S_IDLE:   if (arm_i)   w_state = S_ARMED;
      S_ARMED:  if (w_viol)  w_state = S_HALTED;
      S_HALTED: if (clear_i) w_state = S_ARMED;
      default:  w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_occ   <= '0;
      r_viol  <= 1'b0;
      r_code  <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_occ   <= w_occ;
      r_viol  <= w_viol;
      if (w_viol) begin
        r_code <= w_code;
        if (r_cnt != '1)
          r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == S_HALTED && clear_i) begin
        r_code <= 2'b00;
      end
    end
  end

  // Later port wins when both slots target one entry.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < 2; p++)
      if (w_we[p])
        r_stack[w_wa[p]] <= w_wd[p];
  end

  assign armed_o       = (r_state != S_IDLE);
  assign halt_commit_o = (r_state == S_HALTED);
  assign violation_o   = r_viol;
  assign viol_code_o   = r_code;
  assign viol_cnt_o    = r_cnt;
  assign depth_o       = r_occ;
endmodule

// File: tb/tb_cfi_shadow_stack_ctrl.sv
// Directed bench for cfi_shadow_stack_ctrl: expected output tuples are
// queued as each step is driven and compared when the step's outputs land.
module tb_cfi_shadow_stack_ctrl;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst, arm, clr;
  logic armed, halt, viol;
  logic [1:0] code;
  logic [7:0] cnt;
  logic [4:0] depth;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [4:0] depth;
    logic       viol;
    logic [1:0] code;
    logic       halt;
    logic [7:0] cnt;
    logic       armed;
  } exp_t;

  exp_t q[$];

  cfi_shadow_stack_ctrl_if #(.XLEN(XLEN)) cm ();

  cfi_shadow_stack_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cm_if         (cm),
    .arm_i         (arm),
    .clear_i       (clr),
    .armed_o       (armed),
    .halt_commit_o (halt),
    .violation_o   (viol),
    .viol_code_o   (code),
    .viol_cnt_o    (cnt),
    .depth_o       (depth)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(logic [1:0] ack, logic [1:0] c, logic [1:0] r,
                     logic [63:0] l0, logic [63:0] l1,
                     logic [63:0] t0, logic [63:0] t1);
    cm.commit_ack_i    = ack;
    cm.is_call_i       = c;
    cm.is_ret_i        = r;
    cm.link_addr_i[0]  = l0;
    cm.link_addr_i[1]  = l1;
    cm.ret_target_i[0] = t0;
    cm.ret_target_i[1] = t1;
  endtask

  task automatic idle();
    drv(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
    rst = 1'b0;
    arm = 1'b0;
    clr = 1'b0;
  endtask

  task automatic call0(logic [63:0] l);
    drv(2'b01, 2'b01, 2'b00, l, 64'h0, 64'h0, 64'h0);
  endtask

  task automatic ret0(logic [63:0] t);
    drv(2'b01, 2'b00, 2'b01, 64'h0, 64'h0, t, 64'h0);
  endtask

  task automatic tick(string tag, int d, bit v, logic [1:0] c,
                      bit h, int n, bit a);
    exp_t e;
    e.depth = 5'(d);
    e.viol  = v;
    e.code  = c;
    e.halt  = h;
    e.cnt   = 8'(n);
    e.armed = a;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".depth"}, 32'(depth), 32'(e.depth));
    chk({tag, ".viol"},  32'(viol),  32'(e.viol));
    chk({tag, ".code"},  32'(code),  32'(e.code));
    chk({tag, ".halt"},  32'(halt),  32'(e.halt));
    chk({tag, ".cnt"},   32'(cnt),   32'(e.cnt));
    chk({tag, ".armed"}, 32'(armed), 32'(e.armed));
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick("reset", 0, 0, 2'b00, 0, 0, 0);

    call0(64'h55);
    tick("idle_ev", 0, 0, 2'b00, 0, 0, 0);

    arm = 1'b1;
    call0(64'h66);
    tick("arm_ev", 0, 0, 2'b00, 0, 0, 1);

    call0(64'h8000_0010);
    tick("call", 1, 0, 2'b00, 0, 0, 1);
    ret0(64'h8000_0010);
    tick("ret", 0, 0, 2'b00, 0, 0, 1);

    drv(2'b00, 2'b01, 2'b00, 64'h77, 64'h0, 64'h0, 64'h0);
    tick("no_ack", 0, 0, 2'b00, 0, 0, 1);

    drv(2'b11, 2'b01, 2'b10, 64'h100, 64'h0, 64'h0, 64'h100);
    tick("fwd_ok", 0, 0, 2'b00, 0, 0, 1);
    drv(2'b11, 2'b01, 2'b10, 64'h100, 64'h0, 64'h0, 64'h104);
    tick("fwd_bad", 0, 1, 2'b01, 1, 1, 1);
    tick("hold", 0, 0, 2'b01, 1, 1, 1);
    clr = 1'b1;
    tick("clear1", 0, 0, 2'b00, 0, 1, 1);

    drv(2'b11, 2'b10, 2'b01, 64'h0, 64'h200, 64'h0, 64'h0);
    tick("undflow", 0, 1, 2'b10, 1, 2, 1);
    clr = 1'b1;
    tick("clear2", 0, 0, 2'b00, 0, 2, 1);

    call0(64'h300);
    tick("co_call", 1, 0, 2'b00, 0, 2, 1);
    drv(2'b01, 2'b01, 2'b01, 64'h310, 64'h0, 64'h300, 64'h0);
    tick("co_swap", 1, 0, 2'b00, 0, 2, 1);
    ret0(64'h310);
    tick("co_ret", 0, 0, 2'b00, 0, 2, 1);

    drv(2'b11, 2'b11, 2'b00, 64'h10, 64'h20, 64'h0, 64'h0);
    tick("dual_push", 2, 0, 2'b00, 0, 2, 1);
    drv(2'b11, 2'b00, 2'b11, 64'h0, 64'h0, 64'h20, 64'h10);
    tick("dual_pop", 0, 0, 2'b00, 0, 2, 1);

    drv(2'b11, 2'b11, 2'b00, 64'hA0, 64'hB0, 64'h0, 64'h0);
    tick("pre_push", 2, 0, 2'b00, 0, 2, 1);
    ret0(64'hBAD);
    tick("mism", 1, 1, 2'b01, 1, 3, 1);
    call0(64'hCC);
    tick("halt_ev", 1, 0, 2'b01, 1, 3, 1);
    clr = 1'b1;
    ret0(64'hA0);
    tick("clr_ev", 1, 0, 2'b00, 0, 3, 1);
    ret0(64'hA0);
    tick("kept_top", 0, 0, 2'b00, 0, 3, 1);

    drv(2'b11, 2'b11, 2'b00, 64'h1, 64'h2, 64'h0, 64'h0);
    tick("fill_a", 2, 0, 2'b00, 0, 3, 1);
    drv(2'b11, 2'b11, 2'b00, 64'h3, 64'h4, 64'h0, 64'h0);
    tick("fill_b", 4, 0, 2'b00, 0, 3, 1);
    call0(64'h5);
    tick("fill_c", 5, 0, 2'b00, 0, 3, 1);
    rst = 1'b1;
    arm = 1'b1;
    call0(64'h6);
    tick("mid_rst", 0, 0, 2'b00, 0, 0, 0);
    call0(64'h7);
    tick("post_rst", 0, 0, 2'b00, 0, 0, 0);
    arm = 1'b1;
    tick("rearm", 0, 0, 2'b00, 0, 0, 1);

    for (int i = 0; i < 17; i++) begin
      call0(64'h1000 + 64'(4 * i));
`ifdef CFI_SS_OVERFLOW_TRAP_EN
      if (i == 16)
        tick("ovf_trap", 16, 1, 2'b11, 1, 1, 1);
      else
        tick("ovf_call", i + 1, 0, 2'b00, 0, 0, 1);
`else
      tick("ovf_call", (i < 16) ? i + 1 : 16, 0, 2'b00, 0, 0, 1);
`endif
    end
`ifndef CFI_SS_OVERFLOW_TRAP_EN
    for (int k = 0; k < 16; k++) begin
      ret0(64'h1000 + 64'(4 * (16 - k)));
      tick("wrap_ret", 15 - k, 0, 2'b00, 0, 0, 1);
    end
    ret0(64'h1000);
    tick("wrap_under", 0, 1, 2'b10, 1, 1, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
